hilo_muldiv: RTL and testbench
==============================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  rs operand (multiplicand / dividend).
- b  in  32  rt operand (multiplier / divisor).
- hi_wren  in  1  MTHI write strobe, from the decode stage.
- lo_wren  in  1  MTLO write strobe, from the decode stage.
- wr_data  in  32  data for MTHI/MTLO.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  32  HI register.
- lo  out  32  LO register.
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-003 SHALL implement the FSM IDLE -> RUN -> FIN -> IDLE.
REQ-004 IDLE with start=1 SHALL latch op/a/b and enter RUN; otherwise it SHALL stay in IDLE.
REQ-005 RUN SHALL perform exactly 32 iterations, one per clock:
- multiply: shift-add, one multiplier bit per iteration.
- divide: restoring, one quotient bit per iteration.
REQ-006 RUN SHALL be followed by FIN, which writes HI/LO and returns to IDLE.
REQ-007 Latency: with start sampled at edge 0, HI/LO SHALL update at edge 33, and done SHALL be 1 for exactly the cycle after edge 33.
REQ-008 busy SHALL be 1 from after edge 0 until edge 33 inclusive, and 0 in IDLE.
REQ-009 Multiply SHALL produce a 64-bit product, with {hi,lo} = product:
- MULT: signed.
- MULTU: unsigned.
REQ-010 Signed operands SHALL be converted to magnitudes on entry; the sign SHALL be applied in FIN.
REQ-011 Divide results SHALL be lo = quotient, hi = remainder:
- DIV: quotient truncated toward zero; remainder sign follows the dividend.
REQ-012 b=0 for DIV/DIVU SHALL give hi = a, lo = 32'hFFFFFFFF, with the normal 33-cycle latency.
REQ-013 DIV with a=32'h80000000, b=32'hFFFFFFFF SHALL give lo = 32'h80000000, hi = 0.
REQ-014 hi_wren in IDLE SHALL load hi <= wr_data at the next edge; lo_wren SHALL do the same for lo. Both in the same cycle SHALL update both.
REQ-015 hi_wren/lo_wren while busy=1 SHALL be ignored, and HI/LO SHALL be unchanged until FIN.
REQ-016 start while busy=1 SHALL be ignored; no queuing.
REQ-017 start together with hi_wren/lo_wren in IDLE: the write SHALL take effect at edge 0, and the operation result SHALL overwrite it at FIN.
REQ-018 hi/lo SHALL change only in FIN, on MTHI/MTLO writes, or on reset.

Reset
REQ-019 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, and clear the iteration counter and datapath registers.
REQ-020 Reset asserted during RUN SHALL abort the operation with no partial result. After release, the next start SHALL behave per REQ-007.

Verification
REQ-021 MULT a=32'hFFFFFFFE (-2), b=3 -> at done: hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; done in cycle 34; busy high for 33 cycles.
REQ-022 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-023 DIV a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU a=7, b=0 -> hi=7, lo=32'hFFFFFFFF.
REQ-024 MTHI 32'h12345678 in IDLE -> hi updates next edge.
- Then start DIVU 100/7, with hi_wren=1 at cycle 10 of RUN -> write ignored; at done hi=2, lo=14.
REQ-025 Start MULTU, pulse rst_n low at cycle 15 -> busy/done/hi/lo=0 immediately.
- Then start a new MULT 5*6 -> lo=30, hi=0, done in cycle 34.

Source files
------------

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: 32-iteration shift-add multiply and restoring
// divide, with MTHI/MTLO writes accepted only while idle.
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_wren,
  input  logic        lo_wren,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q, neg_q_q, neg_r_q, dz_q;
  logic [31:0] a_q, d_q;
  logic [63:0] p_q;
  logic        busy_q, done_q;
  logic [31:0] hi_q, lo_q;

  logic        is_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] step_d, prod;
  logic [31:0] quo, rem, res_hi_d, res_lo_d;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // p_q low half holds the multiplier (mult) or dividend (div) and is
  // consumed from the right/left as result bits are shifted in.
  always_comb begin
    mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, d_q} : 33'd0);
    div_ge   = p_q[63:31] >= {1'b0, d_q};
    div_diff = p_q[62:31] - d_q;
    if (is_div_q)
      step_d = div_ge ? {div_diff, p_q[30:0], 1'b1} : {p_q[62:0], 1'b0};
    else
      step_d = {mul_sum, p_q[31:1]};
  end

  always_comb begin
    prod = neg_q_q ? -p_q : p_q;
    quo  = neg_q_q ? -p_q[31:0] : p_q[31:0];
    rem  = neg_r_q ? -p_q[63:32] : p_q[63:32];
    if (!is_div_q) begin
      res_hi_d = prod[63:32];
      res_lo_d = prod[31:0];
    end else if (dz_q) begin
      res_hi_d = a_q;
      res_lo_d = '1;
    end else begin
      res_hi_d = rem;
      res_lo_d = quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_wren) hi_q <= wr_data;
          if (lo_wren) lo_q <= wr_data;
          if (start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= op[1];
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            dz_q     <= (b == '0);
            a_q      <= a;
            d_q      <= op[1] ? b_mag : a_mag;
            p_q      <= {32'd0, op[1] ? a_mag : b_mag};
          end
        end
        S_RUN: begin
          p_q   <= step_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FIN;
        end
        S_FIN: begin
          hi_q    <= res_hi_d;
          lo_q    <= res_lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed vector table, randomized ops against an
// arithmetic reference model, MTHI/MTLO interplay and mid-run reset.
module tb_hilo_muldiv;

  logic        clk, rst_n, start, hi_wren, lo_wren;
  logic [1:0]  op;
  logic [31:0] a, b, wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

  hilo_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_wren(hi_wren), .lo_wren(lo_wren), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    int          wr_at;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic.
  task automatic model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] rhi, output logic [31:0] rlo);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      2'b00: begin p = 64'(sa * sb); rhi = p[63:32]; rlo = p[31:0]; end
      2'b01: begin p = {32'd0, ma} * {32'd0, mb}; rhi = p[63:32]; rlo = p[31:0]; end
      default: begin
        if (mb == 0) begin
          rhi = ma; rlo = 32'hFFFFFFFF;
        end else if (mop == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          rhi = 32'(sr); rlo = 32'(sq);
        end else begin
          rhi = ma % mb; rlo = ma / mb;
        end
      end
    endcase
  endtask

  // Launch one op, watch latency/busy, optionally inject MTHI/MTLO+start:
  // wr_at = 0 alongside start, >0 after that RUN cycle, <0 never.
  task automatic run_op(input string nm, input logic [1:0] vop, input logic [31:0] va,
                        input logic [31:0] vb, input int wr_at,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int          busy_cnt, done_at;
    logic [31:0] base_hi, base_lo;
    logic        changed;
    @(negedge clk);
    start = 1'b1; op = vop; a = va; b = vb;
    wr_data = 32'hA5A55A5A;
    if (wr_at == 0) begin hi_wren = 1'b1; lo_wren = 1'b1; end
    @(posedge clk); #1;
    start = 1'b0; hi_wren = 1'b0; lo_wren = 1'b0;
    if (wr_at == 0) begin
      chk({nm, "_mt_hi_with_start"}, {32'd0, hi}, {32'd0, wr_data});
      chk({nm, "_mt_lo_with_start"}, {32'd0, lo}, {32'd0, wr_data});
    end
    base_hi = hi; base_lo = lo; changed = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (wr_at > 0 && k == wr_at + 1) begin
        hi_wren = 1'b0; lo_wren = 1'b0; start = 1'b0;
      end
      if (done) begin done_at = k; break; end
      if (busy) busy_cnt++;
      if (hi !== base_hi || lo !== base_lo) changed = 1'b1;
      if (wr_at > 0 && k == wr_at) begin
        hi_wren = 1'b1; lo_wren = 1'b1; start = 1'b1; op = ~vop;
      end
    end
    if (done_at < 0) begin
      chk({nm, "_done_timeout"}, 64'd0, 64'd1);
      return;
    end
    chk({nm, "_done_edge"}, 64'(done_at), 64'd33);
    chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({nm, "_hilo_held"}, {63'd0, changed}, 64'd0);
    chk({nm, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({nm, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    @(posedge clk); #1;
    chk({nm, "_done_pulse_busy_after"}, {62'd0, done, busy}, 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] eh, el;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs.push_back('{2'b11, 32'd100,       32'd7,        10, 32'd2,        32'd14});
    vecs.push_back('{2'b00, 32'hFFFFFFFE,  32'd3,        -1, 32'hFFFFFFFF, 32'hFFFFFFFA});
    vecs.push_back('{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF, -1, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{2'b10, 32'hFFFFFFF9,  32'd2,        -1, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{2'b11, 32'd7,         32'd0,        -1, 32'd7,        32'hFFFFFFFF});
    vecs.push_back('{2'b10, 32'h80000000,  32'hFFFFFFFF, -1, 32'd0,        32'h80000000});
    vecs.push_back('{2'b10, 32'hFFFFFFF9,  32'd0,        -1, 32'hFFFFFFF9, 32'hFFFFFFFF});
    vecs.push_back('{2'b00, 32'h80000000,  32'h80000000,  0, 32'h40000000, 32'd0});
    vecs.push_back('{2'b10, 32'd7,         32'hFFFFFFFE, -1, 32'd1,        32'hFFFFFFFD});
    vecs.push_back('{2'b01, 32'd0,         32'h12345678, -1, 32'd0,        32'd0});

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    hi_wren = 1'b0; lo_wren = 1'b0; wr_data = '0;
    #12;
    chk("reset_state", {busy, done, hi, lo}, 66'd0);
    @(negedge clk); rst_n = 1'b1;

    // MTHI alone in IDLE
    @(negedge clk); hi_wren = 1'b1; wr_data = 32'h12345678;
    @(posedge clk); #1; hi_wren = 1'b0;
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});
    chk("mthi_lo_untouched", {32'd0, lo}, 64'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wr_at,
             vecs[i].exp_hi, vecs[i].exp_lo);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 6 == 5) ? 32'd0 : ((i % 4 == 3) ? 32'($urandom_range(1, 300)) : $urandom);
      model(rop, ra, rb, eh, el);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, -1, eh, el);
    end

    // Reset in the middle of a MULTU
    @(negedge clk); start = 1'b1; op = 2'b01; a = 32'hDEADBEEF; b = 32'hCAFEF00D;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 15; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", {busy, done, hi, lo}, 66'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", {busy, done, hi, lo}, 66'd0);
    model(2'b00, 32'd5, 32'd6, eh, el);
    run_op("mult_5x6_after_reset", 2'b00, 32'd5, 32'd6, -1, eh, el);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
